// File: rtl/shift_register_serial_to_parallel_pkg.sv
`default_nettype none
// =============================================================================
// shift_register_serial_parallel_pkg : shared constants/types for the SIPO block
// Rev 1.0
// =============================================================================
package shift_register_serial_parallel_pkg;

  localparam int SR_SP_WIDTH_DEF = 8;

  // Counter width for a modulo-width bit counter; never narrower than 1 bit.
  function automatic int sr_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int SR_SP_CNT_W_DEF = $clog2(SR_SP_WIDTH_DEF);

  typedef logic [SR_SP_CNT_W_DEF-1:0] sr_cnt_t;

endpackage
`default_nettype wire

// File: rtl/shift_register_serial_to_parallel_if.sv
`default_nettype none
// =============================================================================
// shift_register_serial_to_parallel_if : serial-in / parallel-out bus bundle
// Rev 1.0
// =============================================================================
interface shift_register_serial_to_parallel_if
  import shift_register_serial_parallel_pkg::*;
#(
  parameter int WIDTH = SR_SP_WIDTH_DEF
) ();

  localparam int CNT_W = sr_cnt_width(WIDTH);

  logic             enable_i;
  logic             sum_o_out_i;
  logic [WIDTH-1:0] sum_o;
  logic [CNT_W-1:0] bit_cnt_o;
  logic             valid_o;

  modport master (
    output enable_i,
    output sum_o_out_i,
    input  sum_o,
    input  bit_cnt_o,
    input  valid_o
  );

  modport slave (
    input  enable_i,
    input  sum_o_out_i,
    output sum_o,
    output bit_cnt_o,
    output valid_o
  );

endinterface
`default_nettype wire

// File: rtl/shift_register_serial_to_parallel_bit_counter.sv
`default_nettype none
// =============================================================================
// sp_bit_counter : modulo-WIDTH enabled counter with a combinational wrap strobe
// Rev 1.0
// =============================================================================
module sp_bit_counter
  import shift_register_serial_parallel_pkg::*;
#(
  parameter int WIDTH = SR_SP_WIDTH_DEF,
  parameter int CNT_W = sr_cnt_width(WIDTH)
) (
  input  wire logic             clk_i,
  input  wire logic             reset_n_i,
  input  wire logic             enable_i,
  output logic      [CNT_W-1:0] count_o,
  output logic                  wrap_o
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_count;

  // Wrap is asserted on the enabled cycle that accepts the last bit of a word.
  assign wrap_o  = enable_i && (r_count == c_cnt_max);
  assign count_o = r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (enable_i) begin
      r_count <= wrap_o ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_register_serial_to_parallel.sv
`default_nettype none
// =============================================================================
// shift_register_serial_to_parallel : LSB-first SIPO deserializer, pulses valid_o
// per completed word. Build option SR_SP_CAPTURE_EN: sum_o from a capture register.
// Rev 1.0
// =============================================================================
module shift_register_serial_to_parallel
  import shift_register_serial_parallel_pkg::*;
#(
  parameter int WIDTH = SR_SP_WIDTH_DEF
) (
  input wire logic clk_i,
  input wire logic reset_n_i,
  shift_register_serial_to_parallel_if.slave bus
);

  localparam int CNT_W = sr_cnt_width(WIDTH);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_next;
  logic [CNT_W-1:0] w_count;
  logic             w_wrap;
  logic             r_valid;

  // New bits enter at the MSB so the first bit of a word ends in bit 0.
  assign w_sreg_next = {bus.sum_o_out_i, r_sreg[WIDTH-1:1]};

  sp_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enable_i  (bus.enable_i),
    .count_o   (w_count),
    .wrap_o    (w_wrap)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sreg  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_wrap;
      if (bus.enable_i) begin
        r_sreg <= w_sreg_next;
      end
    end
  end

`ifdef SR_SP_CAPTURE_EN
  logic [WIDTH-1:0] r_capture;

  // Loads the word as it stands after the completing shift.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_capture <= '0;
    end else if (w_wrap) begin
      r_capture <= w_sreg_next;
    end
  end

  assign bus.sum_o = r_capture;
`else
  assign bus.sum_o = r_sreg;
`endif

  assign bus.bit_cnt_o = w_count;
  assign bus.valid_o   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_serial_to_parallel.sv
`default_nettype none
// =============================================================================
// tb_shift_register_serial_to_parallel : directed self-checking bench for the SIPO
// Rev 1.0
// =============================================================================
module tb_shift_register_serial_to_parallel;
  import shift_register_serial_parallel_pkg::*;

  localparam int W = 8;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b0;
  bit   chk_on    = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  shift_register_serial_to_parallel_if #(.WIDTH(W)) bus ();

  shift_register_serial_to_parallel #(.WIDTH(W)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  // Model: history of every bit accepted since reset; outputs derived from it.
  logic m_hist [0:255];
  int   m_n     = 0;
  logic m_valid = 1'b0;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_n     <= 0;
      m_valid <= 1'b0;
    end else if (bus.enable_i) begin
      m_hist[m_n % 256] <= bus.sum_o_out_i;
      m_n               <= m_n + 1;
      m_valid           <= ((m_n + 1) % W) == 0;
    end else begin
      m_valid <= 1'b0;
    end
  end

  // Most recent W accepted bits, oldest in bit 0, zeros where none yet.
  function automatic logic [W-1:0] exp_live();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      int idx = m_n - W + i;
      if (idx >= 0) w[i] = m_hist[idx % 256];
    end
    return w;
  endfunction

  // Last fully completed word, or zero when none has completed.
  function automatic logic [W-1:0] exp_cap();
    logic [W-1:0] w = '0;
    int full = (m_n / W) * W;
    if (full > 0) begin
      for (int i = 0; i < W; i++) w[i] = m_hist[(full - W + i) % 256];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_on) begin
`ifdef SR_SP_CAPTURE_EN
      check("model_sum", 32'(bus.sum_o), 32'(exp_cap()));
`else
      check("model_sum", 32'(bus.sum_o), 32'(exp_live()));
`endif
      check("model_cnt", 32'(bus.bit_cnt_o), 32'(m_n % W));
      check("model_valid", 32'(bus.valid_o), 32'(m_valid));
    end
  end

  // Drive one cycle's inputs, then return at the following falling edge.
  task automatic cyc(input logic en, input logic b);
    bus.enable_i    = en;
    bus.sum_o_out_i = b;
    @(negedge clk_i);
  endtask

  task automatic send_word(input logic [W-1:0] word);
    for (int i = 0; i < W; i++) cyc(1'b1, word[i]);
  endtask

  // Assert reset between edges and confirm outputs clear with no clock edge.
  task automatic mid_reset(input string tag);
    bus.enable_i = 1'b0;
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check({tag, "_sum"}, 32'(bus.sum_o), 32'h0);
    check({tag, "_cnt"}, 32'(bus.bit_cnt_o), 32'h0);
    check({tag, "_valid"}, 32'(bus.valid_o), 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    logic [W-1:0] stream [0:1];
    int pulses;
    stream[0] = 8'hA3;
    stream[1] = 8'h5C;
    bus.enable_i    = 1'b0;
    bus.sum_o_out_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    chk_on    = 1'b1;

    // Test 1: build arbitrary state, then asynchronous reset.
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    check("t1_cnt_before", 32'(bus.bit_cnt_o), 32'd5);
    mid_reset("t1_reset");

    // Test 2: one word 0xA3.
    send_word(8'hA3);
    check("t2_sum", 32'(bus.sum_o), 32'hA3);
    check("t2_cnt", 32'(bus.bit_cnt_o), 32'd0);
    check("t2_valid", 32'(bus.valid_o), 32'd1);
    cyc(1'b0, 1'b1);
    check("t2_valid_drop", 32'(bus.valid_o), 32'd0);

    // Test 3: enable gap mid-word with a toggling data input.
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    check("t3_cnt_mid", 32'(bus.bit_cnt_o), 32'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, i[0]);
      check("t3_cnt_hold", 32'(bus.bit_cnt_o), 32'd3);
      check("t3_valid_hold", 32'(bus.valid_o), 32'd0);
    end
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    check("t3_sum", 32'(bus.sum_o), 32'hA3);
    check("t3_valid", 32'(bus.valid_o), 32'd1);
    check("t3_cnt", 32'(bus.bit_cnt_o), 32'd0);

    // Test 4 (and capture-build behaviour): back-to-back 0xA3, 0x5C.
    mid_reset("t4_reset");
    for (int k = 1; k <= 2 * W; k++) begin
      logic [W-1:0] cur;
      cur = stream[(k - 1) / W];
      cyc(1'b1, cur[(k - 1) % W]);
      check("t4_valid", 32'(bus.valid_o), (k == W || k == 2 * W) ? 32'd1 : 32'd0);
      if (k == W)     check("t4_sum_first", 32'(bus.sum_o), 32'hA3);
      if (k == 2 * W) check("t4_sum_second", 32'(bus.sum_o), 32'h5C);
`ifdef SR_SP_CAPTURE_EN
      if (k < W) check("t6_sum_zero", 32'(bus.sum_o), 32'h00);
      else if (k < 2 * W) check("t6_sum_hold", 32'(bus.sum_o), 32'hA3);
`endif
    end
    cyc(1'b0, 1'b0);

    // Test 5: reset after 5 bits discards them; then a fresh 0xFF.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    mid_reset("t5_reset");
    pulses = 0;
    for (int i = 0; i < W; i++) begin
      cyc(1'b1, 1'b1);
      if (bus.valid_o === 1'b1) pulses++;
    end
    check("t5_sum", 32'(bus.sum_o), 32'hFF);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      if (bus.valid_o === 1'b1) pulses++;
    end
    check("t5_pulses", 32'(pulses), 32'd1);
    check("t5_cnt", 32'(bus.bit_cnt_o), 32'd0);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
